// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha keystream controller: FSM state encoding,
// configuration store map and block sizes.
package chacha_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_t;

  // Configuration store map: key, little-endian block counter, nonce.
  localparam int LOAD_BYTES  = 48;
  localparam int KEY_BASE    = 0;
  localparam int CTR_BASE    = 32;
  localparam int NONCE_BASE  = 36;
  localparam int BLOCK_BYTES = 64;

  // True for the four store addresses that hold the block counter.
  function automatic logic is_ctr_addr(input logic [5:0] a);
    return (a >= 6'(CTR_BASE)) && (a < 6'(NONCE_BASE));
  endfunction

endpackage

// File: rtl/chacha_cfg_store.sv
// 48-byte configuration store (key, counter, nonce) with a byte write port,
// an asynchronous read port indexed by the load sequencer, and an in-place
// increment of the 32-bit little-endian block counter.
module chacha_cfg_store
  import chacha_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        ctr_inc,
  input  logic [5:0]  rd_idx,
  output logic [7:0]  rd_data,
  output logic [31:0] ctr_value
);

  logic [7:0] mem [LOAD_BYTES];

  // Byte writes take priority; addresses past the store are ignored.
  // The counter increment only happens while streaming, when writes are blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOAD_BYTES; i++) mem[i] <= 8'h00;
    end else if (we && (addr < 6'(LOAD_BYTES))) begin
      mem[addr] <= wdata;
    end else if (ctr_inc) begin
      {mem[CTR_BASE+3], mem[CTR_BASE+2], mem[CTR_BASE+1], mem[CTR_BASE]} <= ctr_value + 32'd1;
    end
  end

  assign ctr_value = {mem[CTR_BASE+3], mem[CTR_BASE+2], mem[CTR_BASE+1], mem[CTR_BASE]};
  assign rd_data   = (rd_idx < 6'(LOAD_BYTES)) ? mem[rd_idx] : 8'h00;

endmodule

// File: rtl/chacha_ks_ctrl.sv
// ChaCha keystream controller: loads key/counter/nonce into the block core,
// waits for the core, then streams KS_BYTES keystream bytes per block.
// Optional build macro CHACHA_CTR_WRAP_GUARD_EN: stop generation when the
// block counter wraps and refuse new blocks until the counter is rewritten.
//
// Handshake: a keystream byte transfers on a rising edge where ks_valid and
// ks_ready are both high; ks_valid never drops and ks_data holds until then.
module chacha_ks_ctrl
  import chacha_pkg::*;
#(
  parameter int KS_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  output logic        cfg_ready,
  input  logic        run,
  output logic [7:0]  ks_data,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic [7:0]  blk_data_in,
  output logic        blk_write,
  output logic        blk_read,
  input  logic [7:0]  blk_data_out,
  input  logic        blk_ready,
  output logic        busy,
  output logic        ctr_wrap,
  output logic [31:0] ctr_value,
  output state_t      dbg_state
);

  localparam int         KS_N      = (KS_BYTES > BLOCK_BYTES) ? BLOCK_BYTES : KS_BYTES;
  localparam logic [5:0] LAST_IDX  = 6'(KS_N - 1);
  localparam logic [5:0] LAST_LOAD = 6'(LOAD_BYTES - 1);

  state_t     state;
  logic [5:0] load_idx;
  logic [5:0] byte_idx;
  logic       wait_first;
  logic       cfg_acc;
  logic       last_accept;
  logic       wrap_now;
  logic       load_allow;
  logic       stop_after;
  logic [7:0] rd_data;

  assign cfg_ready   = (state == IDLE);
  assign cfg_acc     = cfg_we & cfg_ready;
  assign busy        = (state != IDLE);
  assign blk_write   = (state == LOAD);
  assign ks_valid    = (state == STREAM);
  assign blk_read    = ks_valid & ks_ready;
  assign ks_data     = ks_valid ? blk_data_out : 8'h00;
  assign blk_data_in = blk_write ? rd_data : 8'h00;
  assign dbg_state   = state;

  assign last_accept = blk_read && (byte_idx == LAST_IDX);
  assign wrap_now    = last_accept && (ctr_value == 32'hFFFF_FFFF);

`ifdef CHACHA_CTR_WRAP_GUARD_EN
  assign load_allow = run & ~ctr_wrap;
  assign stop_after = ~run | wrap_now;
`else
  assign load_allow = run;
  assign stop_after = ~run;
`endif

  chacha_cfg_store u_store (
    .clk       (clk),
    .rst       (rst),
    .we        (cfg_acc),
    .addr      (cfg_addr),
    .wdata     (cfg_wdata),
    .ctr_inc   (last_accept),
    .rd_idx    (load_idx),
    .rd_data   (rd_data),
    .ctr_value (ctr_value)
  );

  // Sticky wrap flag, cleared only by rewriting a counter byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_wrap <= 1'b0;
    end else if (wrap_now) begin
      ctr_wrap <= 1'b1;
    end else if (cfg_acc && is_ctr_addr(cfg_addr)) begin
      ctr_wrap <= 1'b0;
    end
  end

  // Block sequencer: LOAD 48 store bytes, WAIT for the core, STREAM the keystream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      load_idx   <= 6'd0;
      byte_idx   <= 6'd0;
      wait_first <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_allow) begin
            state    <= LOAD;
            load_idx <= 6'd0;
          end
        end
        LOAD: begin
          if (load_idx == LAST_LOAD) begin
            state      <= WAIT;
            load_idx   <= 6'd0;
            wait_first <= 1'b1;
          end else begin
            load_idx <= load_idx + 6'd1;
          end
        end
        WAIT: begin
          // blk_ready may still reflect the previous block on the first cycle.
          wait_first <= 1'b0;
          if (!wait_first && blk_ready) begin
            state    <= STREAM;
            byte_idx <= 6'd0;
          end
        end
        STREAM: begin
          if (blk_read) begin
            if (byte_idx == LAST_IDX) begin
              byte_idx <= 6'd0;
              if (stop_after) begin
                state <= IDLE;
              end else begin
                state    <= LOAD;
                load_idx <= 6'd0;
              end
            end else begin
              byte_idx <= byte_idx + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_ks_ctrl.sv
// Bench for chacha_ks_ctrl with a behavioural ChaCha20 block core and a
// keystream scoreboard fed from the bench's own copy of key/counter/nonce.
module tb_chacha_ks_ctrl;
  import chacha_pkg::*;

  localparam int KSB = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = 6'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        cfg_ready;
  logic        run = 1'b0;
  logic [7:0]  ks_data;
  logic        ks_valid;
  logic        ks_ready = 1'b1;
  logic [7:0]  blk_data_in;
  logic        blk_write;
  logic        blk_read;
  logic [7:0]  blk_data_out;
  logic        blk_ready;
  logic        busy;
  logic        ctr_wrap;
  logic [31:0] ctr_value;
  state_t      dbg_state;

  chacha_ks_ctrl #(.KS_BYTES(KSB)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .run(run), .ks_data(ks_data), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .blk_data_in(blk_data_in), .blk_write(blk_write),
    .blk_read(blk_read), .blk_data_out(blk_data_out), .blk_ready(blk_ready),
    .busy(busy), .ctr_wrap(ctr_wrap), .ctr_value(ctr_value), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // ---------------- ChaCha20 reference ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha_blk(input logic [255:0] key, input logic [31:0] ctr,
                                              input logic [95:0] nonce);
    logic [31:0] s [16];
    logic [31:0] w [16];
    logic [511:0] r;
    int qa [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int qb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int qc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int qd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
    w = s;
    for (int rr = 0; rr < 10; rr++) begin
      for (int k = 0; k < 8; k++) begin
        w[qa[k]] += w[qb[k]]; w[qd[k]] ^= w[qa[k]]; w[qd[k]] = rotl(w[qd[k]], 16);
        w[qc[k]] += w[qd[k]]; w[qb[k]] ^= w[qc[k]]; w[qb[k]] = rotl(w[qb[k]], 12);
        w[qa[k]] += w[qb[k]]; w[qd[k]] ^= w[qa[k]]; w[qd[k]] = rotl(w[qd[k]], 8);
        w[qc[k]] += w[qd[k]]; w[qb[k]] ^= w[qc[k]]; w[qb[k]] = rotl(w[qb[k]], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
    return r;
  endfunction

  // ---------------- behavioural block core ----------------
  logic [383:0] core_in;
  logic [383:0] core_full;
  logic [511:0] core_out;
  int           core_wi;
  logic [5:0]   core_ri;
  int           core_lat = 3;
  int           core_cnt;
  logic         core_pend;
  logic         core_rdy;
  logic [31:0]  loaded_ctr_q [$];

  assign core_full    = {blk_data_in, core_in[375:0]};
  assign blk_ready    = core_rdy;
  assign blk_data_out = core_out[{core_ri, 3'b000} +: 8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_wi   <= 0;
      core_ri   <= 6'd0;
      core_cnt  <= 0;
      core_pend <= 1'b0;
      core_rdy  <= 1'b0;
      core_in   <= '0;
      core_out  <= '0;
    end else begin
      if (blk_write) begin
        core_rdy <= 1'b0;
        core_ri  <= 6'd0;
        core_in[core_wi*8 +: 8] <= blk_data_in;
        if (core_wi == 47) begin
          core_wi  <= 0;
          core_out <= chacha_blk(core_full[255:0], core_full[287:256], core_full[383:288]);
          loaded_ctr_q.push_back(core_full[287:256]);
          if (core_lat == 0) core_rdy <= 1'b1;
          else begin
            core_cnt  <= core_lat - 1;
            core_pend <= 1'b1;
          end
        end else begin
          core_wi <= core_wi + 1;
        end
      end else if (core_pend) begin
        if (core_cnt == 0) begin
          core_rdy  <= 1'b1;
          core_pend <= 1'b0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
      if (blk_read) core_ri <= core_ri + 6'd1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [255:0] tb_key;
  logic [31:0]  tb_ctr;
  logic [95:0]  tb_nonce;
  logic [7:0]   exp_q [$];
  logic [7:0]   recv_q [$];
  logic         stall_prev = 1'b0;
  logic [7:0]   stall_data;
  int           stall_cnt = 0;

  task automatic push_block(input logic [31:0] ctr);
    logic [511:0] b;
    b = chacha_blk(tb_key, ctr, tb_nonce);
    for (int i = 0; i < KSB; i++) exp_q.push_back(b[8*i +: 8]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (blk_read !== (ks_valid & ks_ready)) begin
        bad++;
        $display("FAIL blk_read got=%b want=%b", blk_read, ks_valid & ks_ready);
      end
      if (stall_prev) begin
        total++;
        if (ks_valid !== 1'b1 || ks_data !== stall_data) begin
          bad++;
          $display("FAIL stall_hold valid=%b data=%h want=%h", ks_valid, ks_data, stall_data);
        end
      end
      if (ks_valid && !ks_ready) stall_cnt++;
      stall_prev = ks_valid && !ks_ready;
      stall_data = ks_data;
      if (ks_valid && ks_ready) begin
        recv_q.push_back(ks_data);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ks_extra got=%h want=none", ks_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (ks_data !== e) begin
            bad++;
            $display("FAIL ks_byte got=%h want=%h", ks_data, e);
          end
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_wr(input logic [5:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_cfg();
    for (int i = 0; i < 32; i++) cfg_wr(6'(i), tb_key[8*i +: 8]);
    for (int i = 0; i < 4; i++) cfg_wr(6'(32 + i), tb_ctr[8*i +: 8]);
    for (int i = 0; i < 12; i++) cfg_wr(6'(36 + i), tb_nonce[8*i +: 8]);
  endtask

  task automatic pulse_run();
    @(posedge clk); #1; run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_loads(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (loaded_ctr_q.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ks_valid, blk_write, blk_read, busy, ctr_wrap} !== 5'b0 || blk_data_in !== 8'h00 ||
        ks_data !== 8'h00 || ctr_value !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b w=%b r=%b busy=%b wrap=%b din=%h kd=%h ctr=%h want all 0",
               ks_valid, blk_write, blk_read, busy, ctr_wrap, blk_data_in, ks_data, ctr_value);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++;
    if (cfg_ready !== 1'b1 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_idle got cfg_ready=%b state=%0d want 1/%0d", cfg_ready, dbg_state, IDLE);
    end
  endtask

  task automatic test_rfc_vector();
    bit ok;
    logic [7:0] rfc8 [8];
    rfc8 = '{8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15};
    for (int i = 0; i < 32; i++) tb_key[8*i +: 8] = 8'(i);
    tb_ctr   = 32'd1;
    tb_nonce = 96'h00000000_4a000000_09000000;
    load_cfg();
    @(negedge clk);
    total++;
    if (ctr_value !== 32'd1) begin
      bad++;
      $display("FAIL rfc_ctr_cfg got=%h want=00000001", ctr_value);
    end
    recv_q.delete();
    push_block(32'd1);
    pulse_run();
    wait_idle(500, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rfc_timeout got=busy want=idle"); end
    total++;
    if (recv_q.size() != KSB) begin
      bad++;
      $display("FAIL rfc_count got=%0d want=%0d", recv_q.size(), KSB);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (recv_q[i] !== rfc8[i]) begin
          bad++;
          $display("FAIL rfc_byte%0d got=%h want=%h", i, recv_q[i], rfc8[i]);
        end
      end
    end
    total++;
    if (ctr_value !== 32'd2 || dbg_state !== IDLE || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rfc_end got ctr=%h state=%0d left=%0d want 2/IDLE/0", ctr_value, dbg_state, exp_q.size());
    end
  endtask

  task automatic test_wait_latency(input int lat, input int want_wait);
    int wcnt;
    int lcnt;
    bit seen;
    bit ok;
    core_lat = lat;
    push_block(ctr_value);
    pulse_run();
    wcnt = 0; lcnt = 1; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (blk_write) lcnt++;
      if (dbg_state == WAIT) wcnt++;
      if (dbg_state == STREAM) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || wcnt != want_wait) begin
      bad++;
      $display("FAIL wait_cycles lat=%0d got=%0d want=%0d", lat, wcnt, want_wait);
    end
    total++;
    if (lcnt != 49) begin
      bad++;
      $display("FAIL load_cycles got=%0d want=48", lcnt - 1);
    end
    wait_idle(500, ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL wait_block_end got ok=%b left=%0d want 1/0", ok, exp_q.size());
    end
    core_lat = 3;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3:0] pat;
    int c;
    pat = 4'b1001;
    stall_cnt = 0;
    recv_q.delete();
    push_block(ctr_value);
    pulse_run();
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      ks_ready = pat[3 - (c % 4)];
      c++;
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    ks_ready = 1'b1;
    total++;
    if (!ok || recv_q.size() != KSB || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_block got ok=%b recv=%0d left=%0d want 1/%0d/0", ok, recv_q.size(), exp_q.size(), KSB);
    end
    total++;
    if (stall_cnt < 20) begin
      bad++;
      $display("FAIL bp_stalls got=%0d want>=20", stall_cnt);
    end
  endtask

  task automatic test_continuous();
    bit ok;
    int base;
    tb_ctr = 32'd5;
    for (int i = 0; i < 4; i++) cfg_wr(6'(32 + i), tb_ctr[8*i +: 8]);
    recv_q.delete();
    push_block(32'd5); push_block(32'd6); push_block(32'd7);
    base = loaded_ctr_q.size();
    @(posedge clk); #1; run = 1'b1;
    wait_loads(base + 3, 1500, ok);
    run = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL cont_loads got=%0d want=%0d", loaded_ctr_q.size() - base, 3); end
    wait_idle(500, ok);
    total++;
    if (!ok || ctr_value !== 32'd8 || exp_q.size() != 0 || recv_q.size() != 3 * KSB) begin
      bad++;
      $display("FAIL cont_end got ok=%b ctr=%h left=%0d recv=%0d want 1/8/0/%0d",
               ok, ctr_value, exp_q.size(), recv_q.size(), 3 * KSB);
    end
    if (loaded_ctr_q.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (loaded_ctr_q[base + i] !== 32'(5 + i)) begin
          bad++;
          $display("FAIL cont_load_ctr%0d got=%h want=%h", i, loaded_ctr_q[base + i], 32'(5 + i));
        end
      end
    end
    if (recv_q.size() == 3 * KSB) begin
      total++;
      if ({recv_q[0], recv_q[1], recv_q[2], recv_q[3]} == {recv_q[64], recv_q[65], recv_q[66], recv_q[67]} ||
          {recv_q[64], recv_q[65], recv_q[66], recv_q[67]} == {recv_q[128], recv_q[129], recv_q[130], recv_q[131]}) begin
        bad++;
        $display("FAIL cont_distinct got repeated block want distinct");
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    bit stayed;
    int base;
    tb_ctr = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) cfg_wr(6'(32 + i), tb_ctr[8*i +: 8]);
    base = loaded_ctr_q.size();
    push_block(32'hFFFF_FFFF);
`ifdef CHACHA_CTR_WRAP_GUARD_EN
    @(posedge clk); #1; run = 1'b1;
    wait_idle(600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_guard_stop got=busy want=idle"); end
    stayed = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy) stayed = 1'b0;
    end
    run = 1'b0;
    total++;
    if (!stayed || loaded_ctr_q.size() != base + 1) begin
      bad++;
      $display("FAIL wrap_guard_hold got stayed=%b loads=%0d want 1/1", stayed, loaded_ctr_q.size() - base);
    end
    total++;
    if (ctr_wrap !== 1'b1 || ctr_value !== 32'd0) begin
      bad++;
      $display("FAIL wrap_flag got wrap=%b ctr=%h want 1/0", ctr_wrap, ctr_value);
    end
`else
    push_block(32'd0);
    stayed = 1'b1;
    @(posedge clk); #1; run = 1'b1;
    wait_loads(base + 2, 1000, ok);
    run = 1'b0;
    total++;
    if (!ok || loaded_ctr_q[base + 1] !== 32'd0) begin
      bad++;
      $display("FAIL wrap_next_ctr got ok=%b want counter 0 block", ok);
    end
    wait_idle(500, ok);
    total++;
    if (!ok || !stayed || ctr_wrap !== 1'b1 || ctr_value !== 32'd1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_flag got wrap=%b ctr=%h left=%0d want 1/1/0", ctr_wrap, ctr_value, exp_q.size());
    end
`endif
    cfg_wr(6'd33, 8'h00);
    @(negedge clk);
    total++;
    if (ctr_wrap !== 1'b0) begin
      bad++;
      $display("FAIL wrap_clear got=%b want=0", ctr_wrap);
    end
  endtask

  task automatic test_cfg_busy();
    bit ok;
    bit seen;
    tb_ctr = 32'd10;
    for (int i = 0; i < 4; i++) cfg_wr(6'(32 + i), tb_ctr[8*i +: 8]);
    for (int i = 48; i < 64; i++) cfg_wr(6'(i), 8'h5A);
    push_block(32'd10);
    pulse_run();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ks_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL busy_cfg_ready got seen=%b cfg_ready=%b want 1/0", seen, cfg_ready);
    end
    cfg_wr(6'd0, 8'hAA);
    wait_idle(500, ok);
    push_block(32'd11);
    pulse_run();
    wait_idle(500, ok);
    total++;
    if (!ok || ctr_value !== 32'd12 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL busy_next got ok=%b ctr=%h left=%0d want 1/0c/0", ok, ctr_value, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    recv_q.delete();
    push_block(ctr_value);
    pulse_run();
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (recv_q.size() >= 20) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    total++;
    if (!seen || {ks_valid, blk_write, blk_read, busy, ctr_wrap} !== 5'b0 || blk_data_in !== 8'h00 ||
        ks_data !== 8'h00 || ctr_value !== 32'd0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL rst_mid got seen=%b v=%b w=%b r=%b busy=%b wrap=%b ctr=%h state=%0d want all 0",
               seen, ks_valid, blk_write, blk_read, busy, ctr_wrap, ctr_value, dbg_state);
    end
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_after got busy=%b cfg_ready=%b want 0/1", busy, cfg_ready);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rfc_vector();
    test_wait_latency(0, 2);
    test_wait_latency(3, 4);
    test_backpressure();
    test_continuous();
    test_wrap();
    test_cfg_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
